// File: rtl/morse_key_sequencer.sv
// Straight-key front end for the Morse letter decoder: synchronises and debounces the raw key,
// times presses and gaps, and emits one-cycle dot/dash/send codes plus word-space and error pulses.
module morse_key_sequencer #(
    parameter int CNT_W      = 8,
    parameter int DEBOUNCE   = 4,
    parameter int DOT_MAX    = 20,
    parameter int LONG_MAX   = 80,
    parameter int LETTER_GAP = 60,
    parameter int WORD_GAP   = 140
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       key_in,
    output logic [1:0] symbol_out,
    output logic       word_space,
    output logic       err,
    output logic       busy
);

    localparam int DB_W        = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int CNT_ALL_I   = (1 << CNT_W) - 1;
    localparam int PRESS_SAT_I = (LONG_MAX + 1 > CNT_ALL_I) ? CNT_ALL_I : LONG_MAX + 1;

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ALL      = CNT_W'(CNT_ALL_I);
    localparam logic [CNT_W-1:0] PRESS_SAT    = CNT_W'(PRESS_SAT_I);
    localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LONG_MAX_C   = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP);

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_SEND = 2'b11;

    typedef enum logic [1:0] {IDLE, PRESS, LGAP, WGAP} state_t;

    state_t            state;
    logic              key_sync;
    logic              key_s;
    logic              key_db;
    logic [DB_W-1:0]   db_cnt;
    logic [CNT_W-1:0]  press_cnt;
    logic [CNT_W-1:0]  gap_cnt;
    logic [2:0]        sym_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_ALL) ? v : v + CNT_W'(1);
    endfunction

    // Synchroniser and debounce keep running while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync <= 1'b0;
            key_s    <= 1'b0;
            key_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            key_sync <= key_in;
            key_s    <= key_sync;
            if (key_s != key_db) begin
                if (db_cnt == DB_LAST) begin
                    key_db <= key_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            press_cnt  <= '0;
            gap_cnt    <= '0;
            sym_cnt    <= '0;
            symbol_out <= SYM_NONE;
            word_space <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            symbol_out <= SYM_NONE;
            word_space <= 1'b0;
            err        <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                press_cnt <= '0;
                gap_cnt   <= '0;
                sym_cnt   <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_db) begin
                            state     <= PRESS;
                            press_cnt <= CNT_W'(1);
                            busy      <= 1'b1;
                        end
                    end
                    PRESS: begin
                        if (key_db) begin
                            if (press_cnt < PRESS_SAT) press_cnt <= sat_inc(press_cnt);
                        end else begin
                            state   <= LGAP;
                            gap_cnt <= CNT_W'(1);
                            // A fifth symbol or an overlong press is reported, never forwarded.
                            if (sym_cnt == 3'd4 || press_cnt > LONG_MAX_C) begin
                                err <= 1'b1;
                            end else begin
                                symbol_out <= (press_cnt <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
                                sym_cnt    <= sym_cnt + 3'd1;
                            end
                        end
                    end
                    LGAP: begin
                        if (key_db) begin
                            state     <= PRESS;
                            press_cnt <= CNT_W'(1);
                        end else begin
                            gap_cnt <= sat_inc(gap_cnt);
                            if (gap_cnt == LETTER_GAP_C) begin
                                if (sym_cnt != 3'd0) begin
                                    symbol_out <= SYM_SEND;
                                    state      <= WGAP;
                                    sym_cnt    <= '0;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    WGAP: begin
                        if (key_db) begin
                            state     <= PRESS;
                            press_cnt <= CNT_W'(1);
                        end else begin
                            gap_cnt <= sat_inc(gap_cnt);
                            if (gap_cnt == WORD_GAP_C) begin
                                word_space <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboard bench: per-cycle key/reset/enable plan, expected pulses derived from debounced key runs.
module tb_morse_key_sequencer;

    localparam int D    = 2;
    localparam int DOT  = 4;
    localparam int LONG = 12;
    localparam int LG   = 8;
    localparam int WG   = 20;
    localparam int MAXN = 12000;
    localparam int NONE = 1 << 30;

    // Event codes: 1 dot, 2 dash, 3 send, 4 word_space, 5 err
    typedef struct {
        int at;
        int code;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       key_in;
    logic [1:0] symbol_out;
    logic       word_space;
    logic       err;
    logic       busy;

    bit  k_a [MAXN];
    bit  r_a [MAXN];
    bit  e_a [MAXN];
    bit  sy1 [MAXN];
    bit  ks  [MAXN];
    bit  db  [MAXN];
    int  n_edges = 0;
    int  edge_n  = 0;
    int  n_cmp   = 0;
    int  n_bad   = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    morse_key_sequencer #(
        .CNT_W(8), .DEBOUNCE(D), .DOT_MAX(DOT), .LONG_MAX(LONG),
        .LETTER_GAP(LG), .WORD_GAP(WG)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .key_in(key_in),
        .symbol_out(symbol_out), .word_space(word_space), .err(err), .busy(busy)
    );

    task automatic seg(input bit lvl, input int n, input bit r, input bit en_v);
        for (int j = 0; j < n; j++) begin
            if (n_edges < MAXN - 1) begin
                n_edges++;
                k_a[n_edges] = lvl;
                r_a[n_edges] = r;
                e_a[n_edges] = en_v;
            end
        end
    endtask

    task automatic press(input int n);
        seg(1'b1, n, 1'b0, 1'b1);
    endtask

    task automatic gap(input int n);
        seg(1'b0, n, 1'b0, 1'b1);
    endtask

    task automatic add(input int at, input int code, input int fa);
        ev_t ev;
        if (at < fa) begin
            ev.at   = at;
            ev.code = code;
            exp_q.push_back(ev);
        end
    endtask

    // Debounced key per edge, then one pass over press/gap runs of that waveform.
    task automatic build_expect();
        int i, b, ls, ge, len, glen, fa, sym;
        bit flip;
        sy1[0] = 1'b0; ks[0] = 1'b0; db[0] = 1'b0;
        for (int e = 1; e <= n_edges; e++) begin
            sy1[e] = r_a[e] ? 1'b0 : k_a[e];
            ks[e]  = r_a[e] ? 1'b0 : sy1[e-1];
            if (r_a[e]) begin
                db[e] = 1'b0;
            end else begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (e - j < 1) flip = 1'b0;
                    else if (r_a[e-j] || ks[e-j-1] == db[e-1]) flip = 1'b0;
                end
                db[e] = flip ? ks[e-1] : db[e-1];
            end
        end
        sym = 0;
        i = 1;
        while (i <= n_edges) begin
            if (!db[i]) begin
                i++;
            end else begin
                b = i;
                while (b + 1 <= n_edges && db[b+1]) b++;
                len = b - i + 1;
                ls = b + 1;
                if (ls > n_edges) break;
                ge = ls;
                while (ge + 1 <= n_edges && !db[ge+1]) ge++;
                glen = ge - ls + 1;
                fa = NONE;
                for (int e = ls + 1; e <= ls + glen && e <= n_edges; e++)
                    if ((r_a[e] || !e_a[e]) && fa == NONE) fa = e;
                if (sym == 4 || len > LONG) begin
                    add(ls + 1, 5, fa);
                end else begin
                    add(ls + 1, (len <= DOT) ? 1 : 2, fa);
                    sym++;
                end
                if (glen >= LG + 1 && sym > 0) begin
                    add(ls + 1 + LG, 3, fa);
                    sym = 0;
                    if (glen >= WG + 1) add(ls + 1 + WG, 4, fa);
                end
                if (fa != NONE) sym = 0;
                i = ge + 1;
            end
        end
    endtask

    task automatic check_ev(input int code);
        ev_t ev;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event edge %0d: got code %0d, required no event", edge_n, code);
        end else begin
            ev = exp_q.pop_front();
            if (ev.at != edge_n || ev.code != code) begin
                n_bad++;
                $display("FAIL event edge %0d: got code %0d, required code %0d at edge %0d",
                         edge_n, code, ev.code, ev.at);
            end
            n_cmp++;
            if (busy != (code != 4)) begin
                n_bad++;
                $display("FAIL busy edge %0d: got %0b, required %0b", edge_n, busy, code != 4);
            end
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        #1;
        if (reset) begin
            n_cmp++;
            if (symbol_out != 2'b00 || word_space || err || busy) begin
                n_bad++;
                $display("FAIL reset_state edge %0d: sym=%0d ws=%0b err=%0b busy=%0b, required all 0",
                         edge_n, symbol_out, word_space, err, busy);
            end
        end else begin
            if (symbol_out != 2'b00) check_ev(int'(symbol_out));
            if (word_space) check_ev(4);
            if (err) check_ev(5);
        end
    end

    initial begin
        int np;
        reset  = 1'b1;
        enable = 1'b1;
        key_in = 1'b0;

        // Reset held with key down, then a dot and a full word gap
        seg(1'b1, 3, 1'b1, 1'b1);
        press(3); gap(30);
        // Dot, dash, dash, dot
        press(2); gap(3); press(8); gap(3); press(8); gap(3); press(2); gap(30);
        // Glitch, then an overlong press
        press(1); gap(10); press(15); gap(30);
        // Five dots in one letter
        for (int p = 0; p < 5; p++) begin press(2); gap(3); end
        gap(30);
        // Abandon by reset, then by enable, each followed by a fresh letter
        press(2); gap(3); press(2); gap(5); seg(1'b0, 3, 1'b1, 1'b1); gap(25);
        press(2); gap(30);
        press(2); gap(3); press(2); gap(5); seg(1'b0, 4, 1'b0, 1'b0); gap(25);
        press(3); gap(30);
        // Random letters with gaps straddling the letter and word thresholds
        for (int l = 0; l < 30; l++) begin
            np = $urandom_range(1, 6);
            for (int p = 0; p < np; p++) begin
                press($urandom_range(1, 16));
                if (p < np - 1) gap($urandom_range(2, 7));
            end
            if ($urandom_range(0, 5) == 0) begin
                gap($urandom_range(4, 14));
                seg(1'b0, $urandom_range(1, 5), 1'b0, 1'b0);
                gap(25);
            end else begin
                gap($urandom_range(7, 26));
            end
        end
        gap(WG + 15);

        build_expect();

        for (int e = 1; e <= n_edges; e++) begin
            key_in = k_a[e];
            reset  = r_a[e];
            enable = e_a[e];
            @(posedge clk);
            #2;
        end
        repeat (5) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d still pending, first code %0d at edge %0d, required 0 pending",
                     exp_q.size(), exp_q[0].code, exp_q[0].at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
